// File: rtl/ri_text_sequencer.sv
// -----------------------------------------------------------------------------
// ri_text_sequencer
//
// Controller for the random-index text encoder. Accepts one text as a byte
// stream, maps each character to a letter index, strobes the letters into the
// encoder, fires the text-done strobe, captures the thresholded text vector
// and hands it downstream with its label over a valid/ready handshake.
//
// Build option:
//   RI_STRICT_ALPHA_EN  defined   : bytes other than letters/space are dropped
//                                   (no strobe, no count, last still honoured)
//                       undefined : such bytes map to the space index
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   char_valid/ready   upstream byte handshake
//   char_data          ASCII byte
//   char_last          byte is the last of the text
//   char_label         text label, sampled when a new text starts
//   enc_rst_n          encoder clear, 1-cycle active-low pulse
//   enc_letter         encoder letter index
//   enc_letter_ready   encoder letter strobe
//   enc_text_done      encoder threshold strobe
//   enc_text_vector    encoder thresholded output
//   vec_data/label     captured hypervector and label
//   vec_count          letters strobed for this text
//   vec_short          vec_count < MIN_LETTERS
//   vec_valid/ready    downstream result handshake
// -----------------------------------------------------------------------------
module ri_text_sequencer #(
   parameter int unsigned N           = 10000,
   parameter int unsigned MAXLETTERS  = 27,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned MIN_LETTERS = 4,
   parameter int unsigned LABEL_W     = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               char_valid,
   input  logic [7:0]         char_data,
   input  logic               char_last,
   input  logic [LABEL_W-1:0] char_label,
   output logic               char_ready,
   output logic               enc_rst_n,
   output logic [4:0]         enc_letter,
   output logic               enc_letter_ready,
   output logic               enc_text_done,
   input  logic [N-1:0]       enc_text_vector,
   output logic [N-1:0]       vec_data,
   output logic [LABEL_W-1:0] vec_label,
   output logic [CNT_W-1:0]   vec_count,
   output logic               vec_short,
   output logic               vec_valid,
   input  logic               vec_ready
);

   localparam logic [4:0] SPACE_IDX = 5'(MAXLETTERS - 1);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FETCH,
      STROBE,
      DRAIN,
      DONE,
      CAPTURE,
      REPORT
   } state_t;

   state_t state_q, state_d;

   logic [LABEL_W-1:0] label_q, label_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [4:0]         letter_q, letter_d;
   logic               last_q, last_d;
   logic [N-1:0]       vec_data_q, vec_data_d;
   logic [LABEL_W-1:0] vec_label_q, vec_label_d;
   logic [CNT_W-1:0]   vec_count_q, vec_count_d;
   logic               vec_short_q, vec_short_d;

   logic [7:0] ch_fold;
   logic [4:0] map_idx;
   logic       map_ok;
   logic       char_hs;

   // ---------------------------------------------------------------------
   // Character mapping: fold uppercase, then letter / space / other
   // ---------------------------------------------------------------------
   always_comb begin
      ch_fold = char_data;
      if (char_data >= 8'h41 && char_data <= 8'h5A) begin
         ch_fold = char_data + 8'h20;
      end
      map_ok  = 1'b1;
      map_idx = SPACE_IDX;
      if (ch_fold >= 8'h61 && ch_fold <= 8'h7A) begin
         map_idx = 5'(ch_fold - 8'h61);
      end else if (ch_fold == 8'h20) begin
         map_idx = SPACE_IDX;
      end else begin
`ifdef RI_STRICT_ALPHA_EN
         map_ok = 1'b0;
`else
         map_ok = 1'b1;
`endif
      end
   end

   assign char_hs = (state_q == FETCH) && char_valid;

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (char_valid) state_d = CLEAR;
         CLEAR:   state_d = FETCH;
         FETCH: begin
            if (char_valid) begin
               if (map_ok)         state_d = STROBE;
               else if (char_last) state_d = DRAIN;
            end
         end
         STROBE:  state_d = last_q ? DRAIN : FETCH;
         DRAIN:   state_d = DONE;
         DONE:    state_d = CAPTURE;
         CAPTURE: state_d = REPORT;
         REPORT:  if (vec_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs (decoded from the registered state, one-hot pulses)
   // ---------------------------------------------------------------------
   always_comb begin
      char_ready       = 1'b0;
      enc_rst_n        = 1'b1;
      enc_letter_ready = 1'b0;
      enc_text_done    = 1'b0;
      vec_valid        = 1'b0;
      unique case (state_q)
         CLEAR:   enc_rst_n        = 1'b0;
         FETCH:   char_ready       = 1'b1;
         STROBE:  enc_letter_ready = 1'b1;
         DONE:    enc_text_done    = 1'b1;
         REPORT:  vec_valid        = 1'b1;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath next-state
   // ---------------------------------------------------------------------
   always_comb begin
      label_d     = label_q;
      count_d     = count_q;
      letter_d    = letter_q;
      last_d      = last_q;
      vec_data_d  = vec_data_q;
      vec_label_d = vec_label_q;
      vec_count_d = vec_count_q;
      vec_short_d = vec_short_q;

      if (state_q == IDLE && char_valid) begin
         label_d = char_label;
      end
      if (state_q == CLEAR) begin
         count_d = '0;
      end
      if (char_hs && map_ok) begin
         letter_d = map_idx;
         last_d   = char_last;
      end
      if (state_q == STROBE && count_q != '1) begin
         count_d = count_q + CNT_W'(1);
      end
      if (state_q == CAPTURE) begin
         vec_data_d  = enc_text_vector;
         vec_label_d = label_q;
         vec_count_d = count_q;
         vec_short_d = (count_q < CNT_W'(MIN_LETTERS));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         label_q     <= '0;
         count_q     <= '0;
         letter_q    <= SPACE_IDX;
         last_q      <= 1'b0;
         vec_data_q  <= '0;
         vec_label_q <= '0;
         vec_count_q <= '0;
         vec_short_q <= 1'b0;
      end else begin
         label_q     <= label_d;
         count_q     <= count_d;
         letter_q    <= letter_d;
         last_q      <= last_d;
         vec_data_q  <= vec_data_d;
         vec_label_q <= vec_label_d;
         vec_count_q <= vec_count_d;
         vec_short_q <= vec_short_d;
      end
   end

   // The index is presented in the accepting cycle (from letter_d) and then
   // held by letter_q through the strobe, so the encoder sees it one full
   // cycle ahead of enc_letter_ready without stretching the 2-cycle letter
   // rate. Outside an accepting cycle letter_d equals letter_q.
   assign enc_letter = letter_d;

   assign vec_data  = vec_data_q;
   assign vec_label = vec_label_q;
   assign vec_count = vec_count_q;
   assign vec_short = vec_short_q;

endmodule

// File: tb/tb_ri_text_sequencer.sv
module tb_ri_text_sequencer;

   localparam int unsigned N       = 64;
   localparam int unsigned LABEL_W = 5;
   localparam int unsigned CNT_W   = 32;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               char_valid = 1'b0;
   logic [7:0]         char_data = '0;
   logic               char_last = 1'b0;
   logic [LABEL_W-1:0] char_label = '0;
   logic               char_ready;
   logic               enc_rst_n;
   logic [4:0]         enc_letter;
   logic               enc_letter_ready;
   logic               enc_text_done;
   logic [N-1:0]       enc_text_vector = '0;
   logic [N-1:0]       vec_data;
   logic [LABEL_W-1:0] vec_label;
   logic [CNT_W-1:0]   vec_count;
   logic               vec_short;
   logic               vec_valid;
   logic               vec_ready = 1'b1;

   ri_text_sequencer #(
      .N(N), .MAXLETTERS(27), .CNT_W(CNT_W), .MIN_LETTERS(4), .LABEL_W(LABEL_W)
   ) dut (
      .clk(clk), .rst(rst),
      .char_valid(char_valid), .char_data(char_data), .char_last(char_last),
      .char_label(char_label), .char_ready(char_ready),
      .enc_rst_n(enc_rst_n), .enc_letter(enc_letter),
      .enc_letter_ready(enc_letter_ready), .enc_text_done(enc_text_done),
      .enc_text_vector(enc_text_vector),
      .vec_data(vec_data), .vec_label(vec_label), .vec_count(vec_count),
      .vec_short(vec_short), .vec_valid(vec_valid), .vec_ready(vec_ready)
   );

   always #5 clk = ~clk;

   int total_cnt = 0;
   int pass_cnt  = 0;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Encoder output stand-in: changes every cycle so capture timing matters.
   initial begin
      forever begin
         @(posedge clk);
         #1 enc_text_vector = {$urandom, $urandom};
      end
   end

   // Event log, sampled on the falling edge
   int         strobe_q[$];
   int         pre_bad = 0;
   int         strobe_cyc = 0;
   int         done_cnt = 0;
   int         done_cyc = 0;
   int         clr_cnt = 0;
   int         ovl = 0;
   bit         cap_pend = 0;
   logic [N-1:0] cap_vec = '0;
   logic [4:0] prev_letter = 5'd26;

   initial begin
      forever begin
         @(negedge clk);
         if (enc_letter_ready === 1'b1) begin
            strobe_q.push_back(int'(enc_letter));
            strobe_cyc = cyc;
            if (prev_letter !== enc_letter) pre_bad++;
         end
         if (cap_pend) begin
            cap_vec  = enc_text_vector;
            cap_pend = 0;
         end
         if (enc_text_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            cap_pend = 1;
         end
         if (enc_rst_n === 1'b0) clr_cnt++;
         if ((int'(enc_letter_ready === 1'b1) + int'(enc_text_done === 1'b1) +
              int'(enc_rst_n === 1'b0)) > 1) ovl++;
         prev_letter = enc_letter;
      end
   end

   function automatic bit q_eq(input int a[$], input int b[$]);
      if (a.size() != b.size()) return 0;
      foreach (a[i]) if (a[i] != b[i]) return 0;
      return 1;
   endfunction

   function automatic string q_str(input int a[$]);
      string s = "{";
      foreach (a[i]) s = {s, $sformatf("%0d ", a[i])};
      return {s, "}"};
   endfunction

   task automatic clear_log();
      strobe_q.delete();
      pre_bad  = 0;
      done_cnt = 0;
      clr_cnt  = 0;
      cap_pend = 0;
   endtask

   // Presents one byte and holds it until accepted (bounded wait).
   task automatic send_char(input logic [7:0] c, input logic last,
                            input logic [LABEL_W-1:0] lab, output int hs_cyc);
      bit hs = 0;
      hs_cyc     = 0;
      char_valid = 1'b1;
      char_data  = c;
      char_last  = last;
      char_label = lab;
      for (int i = 0; i < 40 && !hs; i++) begin
         @(negedge clk);
         if (char_ready === 1'b1) begin
            hs     = 1;
            hs_cyc = cyc;
         end
         @(posedge clk);
         #1;
      end
      char_valid = 1'b0;
      char_last  = 1'b0;
      if (!hs) begin
         total_cnt++;
         $display("FAIL handshake: byte %h not accepted within 40 cycles, required accept", c);
      end
   endtask

   task automatic send_text(input string s, input logic [LABEL_W-1:0] lab,
                            output int hs_cyc);
      for (int i = 0; i < s.len(); i++) begin
         send_char(s[i], (i == s.len() - 1), lab, hs_cyc);
      end
   endtask

   // Returns on the falling edge where vec_valid is first seen (bounded).
   task automatic wait_result(output int vcyc);
      bit got = 0;
      vcyc = 0;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         if (vec_valid === 1'b1) begin
            got  = 1;
            vcyc = cyc;
         end
      end
      if (!got) begin
         total_cnt++;
         $display("FAIL result_timeout: vec_valid never rose within 60 cycles, required 1");
      end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total_cnt++;
      if ({char_ready, enc_rst_n, enc_letter_ready, enc_text_done, vec_valid, vec_short}
          !== 6'b010000)
         $display("FAIL reset_ctrl: got %b required 010000",
                  {char_ready, enc_rst_n, enc_letter_ready, enc_text_done, vec_valid, vec_short});
      else pass_cnt++;
      total_cnt++;
      if (enc_letter !== 5'd26)
         $display("FAIL reset_letter: got %0d required 26", enc_letter);
      else pass_cnt++;
      total_cnt++;
      if (vec_data !== '0 || vec_label !== '0 || vec_count !== '0)
         $display("FAIL reset_vec: got data %h label %0d count %0d required 0 0 0",
                  vec_data, vec_label, vec_count);
      else pass_cnt++;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_abcd();
      int hs, vc;
      int exp[$];
      exp = '{0, 1, 2, 3};
      clear_log();
      send_text("abcd", 5'd7, hs);
      wait_result(vc);
      total_cnt++;
      if (!q_eq(strobe_q, exp))
         $display("FAIL abcd_idx: got %s required %s", q_str(strobe_q), q_str(exp));
      else pass_cnt++;
      total_cnt++;
      if (pre_bad != 0)
         $display("FAIL abcd_idx_setup: got %0d unstable indices required 0", pre_bad);
      else pass_cnt++;
      total_cnt++;
      if (clr_cnt != 1 || done_cnt != 1)
         $display("FAIL abcd_pulses: got clr %0d done %0d required 1 1", clr_cnt, done_cnt);
      else pass_cnt++;
      total_cnt++;
      if (done_cyc - strobe_cyc != 2)
         $display("FAIL abcd_done_gap: got %0d required 2", done_cyc - strobe_cyc);
      else pass_cnt++;
      total_cnt++;
      if (vc - hs != 5)
         $display("FAIL abcd_latency: got %0d required 4", vc - hs - 1);
      else pass_cnt++;
      total_cnt++;
      if (vec_label !== 5'd7 || vec_count !== 32'd4 || vec_short !== 1'b0)
         $display("FAIL abcd_vec: got label %0d count %0d short %b required 7 4 0",
                  vec_label, vec_count, vec_short);
      else pass_cnt++;
      total_cnt++;
      if (vec_data !== cap_vec)
         $display("FAIL abcd_data: got %h required %h", vec_data, cap_vec);
      else pass_cnt++;
   endtask

   task automatic test_upper_space();
      int hs, vc;
      int exp[$];
      exp = '{0, 1};
      @(posedge clk); #1;
      clear_log();
      send_text("AB", 5'd3, hs);
      wait_result(vc);
      total_cnt++;
      if (!q_eq(strobe_q, exp))
         $display("FAIL upper_idx: got %s required %s", q_str(strobe_q), q_str(exp));
      else pass_cnt++;
      total_cnt++;
      if (vec_count !== 32'd2 || vec_short !== 1'b1 || vec_label !== 5'd3)
         $display("FAIL upper_vec: got count %0d short %b label %0d required 2 1 3",
                  vec_count, vec_short, vec_label);
      else pass_cnt++;

      exp = '{25, 26, 25};
      @(posedge clk); #1;
      clear_log();
      send_text("z Z", 5'd1, hs);
      wait_result(vc);
      total_cnt++;
      if (!q_eq(strobe_q, exp) || vec_count !== 32'd3)
         $display("FAIL space_idx: got %s count %0d required %s count 3",
                  q_str(strobe_q), vec_count, q_str(exp));
      else pass_cnt++;
   endtask

   task automatic test_nonalpha();
      int hs, vc;
      int exp[$];
      int exp_cnt, exp_lat;
`ifdef RI_STRICT_ALPHA_EN
      exp = '{0, 1};
      exp_cnt = 2;
`else
      exp = '{0, 26, 1};
      exp_cnt = 3;
`endif
      @(posedge clk); #1;
      clear_log();
      send_text("a1b", 5'd12, hs);
      wait_result(vc);
      total_cnt++;
      if (!q_eq(strobe_q, exp) || vec_count !== 32'(exp_cnt))
         $display("FAIL a1b: got %s count %0d required %s count %0d",
                  q_str(strobe_q), vec_count, q_str(exp), exp_cnt);
      else pass_cnt++;

`ifdef RI_STRICT_ALPHA_EN
      exp = {};
      exp_cnt = 0;
      exp_lat = 4;
`else
      exp = '{26};
      exp_cnt = 1;
      exp_lat = 5;
`endif
      @(posedge clk); #1;
      clear_log();
      send_text("9", 5'd2, hs);
      wait_result(vc);
      total_cnt++;
      if (!q_eq(strobe_q, exp) || done_cnt != 1)
         $display("FAIL digit_pulses: got %s done %0d required %s done 1",
                  q_str(strobe_q), done_cnt, q_str(exp));
      else pass_cnt++;
      total_cnt++;
      if (vec_count !== 32'(exp_cnt) || vec_short !== 1'b1)
         $display("FAIL digit_vec: got count %0d short %b required %0d 1",
                  vec_count, vec_short, exp_cnt);
      else pass_cnt++;
      total_cnt++;
      if (vc - hs != exp_lat)
         $display("FAIL digit_latency: got %0d required %0d", vc - hs - 1, exp_lat - 1);
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      int hs, vc;
      bit bad = 0;
      logic [N-1:0] snap_d;
      logic [CNT_W-1:0] snap_c;
      logic [LABEL_W-1:0] snap_l;
      @(posedge clk); #1;
      vec_ready = 1'b0;
      clear_log();
      send_text("hi", 5'd2, hs);
      wait_result(vc);
      snap_d = vec_data;
      snap_c = vec_count;
      snap_l = vec_label;
      total_cnt++;
      if (snap_c !== 32'd2 || snap_l !== 5'd2)
         $display("FAIL bp_vec: got count %0d label %0d required 2 2", snap_c, snap_l);
      else pass_cnt++;
      @(posedge clk); #1;
      char_valid = 1'b1;
      char_data  = "q";
      char_last  = 1'b1;
      char_label = 5'd5;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (char_ready !== 1'b0 || vec_valid !== 1'b1 || vec_data !== snap_d ||
             vec_count !== snap_c || vec_label !== snap_l) bad = 1;
         @(posedge clk); #1;
      end
      total_cnt++;
      if (bad)
         $display("FAIL bp_hold: got a change during back-pressure required stable");
      else pass_cnt++;
      clear_log();
      vec_ready = 1'b1;
      send_char("q", 1'b1, 5'd5, hs);
      wait_result(vc);
      total_cnt++;
      if (clr_cnt != 1 || vec_count !== 32'd1 || vec_label !== 5'd5)
         $display("FAIL bp_next: got clr %0d count %0d label %0d required 1 1 5",
                  clr_cnt, vec_count, vec_label);
      else pass_cnt++;
   endtask

   task automatic test_midtext_reset();
      int hs, vc;
      int exp[$];
      @(posedge clk); #1;
      clear_log();
      send_char("a", 1'b0, 5'd9, hs);
      send_char("b", 1'b0, 5'd9, hs);
      @(posedge clk); #1;
      char_valid = 1'b1;
      char_data  = "c";
      rst = 1'b1;
      #1;
      total_cnt++;
      if (strobe_q.size() != 2)
         $display("FAIL rst_pre_strobes: got %0d required 2", strobe_q.size());
      else pass_cnt++;
      total_cnt++;
      if ({char_ready, enc_rst_n, enc_letter_ready, enc_text_done, vec_valid, vec_short} !== 6'b010000 ||
          enc_letter !== 5'd26 || vec_data !== '0 || vec_count !== '0 || vec_label !== '0)
         $display("FAIL rst_async: got ctrl %b letter %0d count %0d label %0d required 010000 26 0 0",
                  {char_ready, enc_rst_n, enc_letter_ready, enc_text_done, vec_valid, vec_short},
                  enc_letter, vec_count, vec_label);
      else pass_cnt++;
      char_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      total_cnt++;
      if (done_cnt != 0)
         $display("FAIL rst_no_done: got %0d required 0", done_cnt);
      else pass_cnt++;
      exp = '{23, 24};
      clear_log();
      send_text("xy", 5'd4, hs);
      wait_result(vc);
      total_cnt++;
      if (!q_eq(strobe_q, exp) || clr_cnt != 1 || vec_count !== 32'd2 || vec_label !== 5'd4)
         $display("FAIL rst_next: got %s clr %0d count %0d label %0d required %s 1 2 4",
                  q_str(strobe_q), clr_cnt, vec_count, vec_label, q_str(exp));
      else pass_cnt++;
   endtask

   initial begin
      #1;
      test_reset();
      test_abcd();
      test_upper_space();
      test_nonalpha();
      test_backpressure();
      test_midtext_reset();
      total_cnt++;
      if (ovl != 0)
         $display("FAIL pulse_overlap: got %0d overlapping cycles required 0", ovl);
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/ri_text_sequencer.md
Name: ri_text_sequencer

Overview:
- Controller for the random-index text encoder. It takes one text from a byte stream (valid/ready) and maps each character to a letter index.
- It strobes letters into the encoder with the required one-cycle index-to-strobe offset, then issues the text-done pulse.
- It captures the thresholded text hypervector and hands it downstream with a label over a valid/ready handshake.
- It sits between the text reader / testbench feeder and the encoder, and is used for both training and query passes.

Parameters:
- N, 10000, hypervector width.
- MAXLETTERS, 27, alphabet size: a..z map to indices 0..25; space maps to 26.
- CNT_W, 32, width of the letter counter.
- MIN_LETTERS, 4, minimum letters for one valid n-gram (3 fill cycles + 1).
- LABEL_W, 5, width of the text/language label.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- char_valid  in  1  upstream character valid
- char_data  in  8  ASCII character
- char_last  in  1  character is the last of the text
- char_label  in  LABEL_W  label, sampled with the first character of a text
- char_ready  out  1  character accepted when char_valid && char_ready
- enc_rst_n  out  1  encoder clear, active-low synchronous pulse
- enc_letter  out  5  encoder letter index
- enc_letter_ready  out  1  encoder letter strobe
- enc_text_done  out  1  encoder threshold strobe
- enc_text_vector  in  N  encoder thresholded output
- vec_data  out  N  captured text hypervector
- vec_label  out  LABEL_W  captured label
- vec_count  out  CNT_W  letters strobed for this text
- vec_short  out  1  vec_count < MIN_LETTERS
- vec_valid  out  1  result valid
- vec_ready  in  1  downstream accepts result

Behaviour:
- Reset (async, any state): state=IDLE.
  - All outputs 0, except enc_rst_n=1 and enc_letter=26.
  - Counter, label and vec_* registers cleared.
  - A reset in mid-text discards that text. The encoder is re-cleared when the next text starts.
- IDLE: char_ready=0.
  - If char_valid: latch char_label and go to CLEAR. The character is not consumed.
- CLEAR (1 cycle): enc_rst_n=0, count=0, then go to FETCH.
- FETCH: char_ready=1. On handshake:
  - Uppercase A..Z is folded to lowercase.
  - a..z gives index 0..25. Space gives 26.
  - Any other byte: see the optional feature.
  - Mapped character: register enc_letter=index, latch char_last, go to STROBE.
  - Dropped character with char_last=1: go to DRAIN. Dropped with char_last=0: stay in FETCH.
- STROBE (1 cycle): char_ready=0, enc_letter_ready=1, enc_letter held.
  - count += 1, saturating at 2^CNT_W-1.
  - If the latched last flag is set, go to DRAIN; otherwise go to FETCH.
  - Peak rate: 1 letter per 2 cycles.
  - enc_letter is always stable at least one full cycle before and during the strobe.
- DRAIN (1 cycle): lets the encoder's final counter update settle. Next state is DONE.
- DONE (1 cycle): enc_text_done=1, then go to CAPTURE.
- CAPTURE (1 cycle):
  - vec_data <= enc_text_vector.
  - vec_count <= count; vec_label <= latched label; vec_short <= (count < MIN_LETTERS).
  - Go to REPORT.
- REPORT: vec_valid=1, and vec_* are stable while vec_valid is high.
  - On vec_ready: vec_valid=0 next cycle, go to IDLE.
  - char_ready stays 0 until the result is taken (back-pressure).
- Empty text (only dropped characters): the flow still goes DRAIN, DONE, CAPTURE, REPORT, with count=0 and vec_short=1.
- enc_letter_ready, enc_text_done and enc_rst_n pulses are exactly 1 cycle and never overlap.
- Latency: last character handshake to vec_valid is 4 cycles if the last character is mapped (STROBE, DRAIN, DONE, CAPTURE), or 3 cycles if it is dropped.

Optional Feature:
- Macro: RI_STRICT_ALPHA_EN.
- Defined: bytes other than letters and space are dropped. There is no strobe and no count, but char_last is still honoured.
- Undefined: every other byte maps to index 26 (space) and is strobed normally.

Test Plan:
- "abcd" with last on 'd', label 7, vec_ready=1:
  - 1 enc_rst_n pulse, then 4 enc_letter_ready pulses with indices 0,1,2,3, each index valid 1 cycle before its strobe.
  - One enc_text_done pulse 2 cycles after the 4th strobe.
  - vec_valid with vec_label=7, vec_count=4, vec_short=0.
  - vec_data equals enc_text_vector sampled the cycle after enc_text_done.
- "AB" (uppercase) -> indices 0,1; vec_count=2; vec_short=1.
- "a1b" + last:
  - Without RI_STRICT_ALPHA_EN: indices 0,26,1 and vec_count=3.
  - With it: indices 0,1 and vec_count=2.
- Single "9" with last, RI_STRICT_ALPHA_EN defined -> no strobes; one enc_text_done; vec_count=0; vec_short=1.
- vec_ready held 0 for 10 cycles in REPORT while char_valid=1 -> char_ready stays 0 and vec_* stay stable. After vec_ready, the next text starts with an enc_rst_n pulse.
- rst asserted after the 2nd strobe of a 6-letter text -> all outputs return to reset values at once, and there is no enc_text_done. The following text reports only its own count.
